// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the 4-to-2 encoder/serializer return path.
package encoder_pkg;

    localparam int N_LINES = 4;
    localparam int IDX_W   = 2;

    // Converts a 2-bit line index into its one-hot request mask.
    function automatic logic [N_LINES-1:0] onehot2(input logic [IDX_W-1:0] idx);
        logic [N_LINES-1:0] mask_s;
        case (idx)
            2'd0:    mask_s = 4'b0001;
            2'd1:    mask_s = 4'b0010;
            2'd2:    mask_s = 4'b0100;
            2'd3:    mask_s = 4'b1000;
            default: mask_s = 4'b0000;
        endcase
        return mask_s;
    endfunction

endpackage

// File: rtl/pri_sel4.sv
// Combinational 4-line selector: fixed priority (line 3 highest) or
// round-robin search beginning at line 'start'.
module pri_sel4
    import encoder_pkg::*;
(
    input  logic [N_LINES-1:0] P,
    input  logic [IDX_W-1:0]   start,
    input  logic               rr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [N_LINES-1:0] rot_s;
    logic [IDX_W-1:0]   fix_idx_s;
    logic [IDX_W-1:0]   rr_off_s;

    // Fixed priority: highest set bit wins.
    always_comb begin
        fix_idx_s = 2'd0;
        casez (P)
            4'b1???: fix_idx_s = 2'd3;
            4'b01??: fix_idx_s = 2'd2;
            4'b001?: fix_idx_s = 2'd1;
            4'b0001: fix_idx_s = 2'd0;
            default: fix_idx_s = 2'd0;
        endcase
    end

    // Rotate so bit 0 is line 'start', then take the lowest set bit as an offset.
    always_comb begin
        rot_s    = P;
        rr_off_s = 2'd0;
        case (start)
            2'd0:    rot_s = P;
            2'd1:    rot_s = {P[0],   P[3:1]};
            2'd2:    rot_s = {P[1:0], P[3:2]};
            2'd3:    rot_s = {P[2:0], P[3]};
            default: rot_s = P;
        endcase
        casez (rot_s)
            4'b???1: rr_off_s = 2'd0;
            4'b??10: rr_off_s = 2'd1;
            4'b?100: rr_off_s = 2'd2;
            4'b1000: rr_off_s = 2'd3;
            default: rr_off_s = 2'd0;
        endcase
    end

    // Final index selection by arbitration mode.
    always_comb begin
        any = |P;
        if (rr) begin
            idx = start + rr_off_s;
        end else begin
            idx = fix_idx_s;
        end
    end

endmodule

// File: rtl/encoder4x2_serializer.sv
// Captures one-hot request pulses into a pending register and serializes them
// as 2-bit codes over a valid/ready handshake.
module encoder4x2_serializer
    import encoder_pkg::*;
#(
    parameter int RR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               E,
    input  logic [N_LINES-1:0] D,
    output logic [IDX_W-1:0]   A,
    output logic               V,
    input  logic               R,
    output logic [N_LINES-1:0] P,
    output logic               OVF
);

    logic [N_LINES-1:0] p_r;
    logic [IDX_W-1:0]   a_r;
    logic               v_r;
    logic [IDX_W-1:0]   last_r;
    logic               ovf_r;

    logic [N_LINES-1:0] cap_s;
    logic [N_LINES-1:0] clr_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic               sel_any_s;
    logic               load_s;
    logic [IDX_W-1:0]   start_s;
    logic               rr_s;

    assign rr_s    = (RR != 0);
    assign start_s = last_r + 2'd1;

    pri_sel4 u_sel (
        .P     (p_r),
        .start (start_s),
        .rr    (rr_s),
        .idx   (sel_idx_s),
        .any   (sel_any_s)
    );

    // Slot loads when it is empty or being drained, and something is pending.
    always_comb begin
        cap_s  = E ? D : 4'b0000;
        load_s = (!v_r || R) && sel_any_s;
        if (load_s) begin
            clr_s = onehot2(sel_idx_s);
        end else begin
            clr_s = 4'b0000;
        end
    end

    // Pending, output slot, round-robin pointer and overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_r    <= 4'b0000;
            a_r    <= 2'b00;
            v_r    <= 1'b0;
            last_r <= 2'b11;
            ovf_r  <= 1'b0;
        end else begin
            p_r   <= (p_r & ~clr_s) | cap_s;
            ovf_r <= |(cap_s & p_r & ~clr_s);
            if (load_s) begin
                a_r    <= sel_idx_s;
                v_r    <= 1'b1;
                last_r <= sel_idx_s;
            end else if (v_r && R) begin
                v_r <= 1'b0;
            end else begin
                v_r <= v_r;
            end
        end
    end

    assign A   = a_r;
    assign V   = v_r;
    assign P   = p_r;
    assign OVF = ovf_r;

endmodule

// File: tb/tb_encoder4x2_serializer.sv
// Self-checking bench: fixed-priority and round-robin instances driven in
// parallel, checked against a cycle-level reference model and directed constants.
module tb_encoder4x2_serializer;

    logic       clk;
    logic       rst;
    logic       E;
    logic [3:0] D;
    logic       R;

    logic [1:0] a0, a1;
    logic       v0, v1;
    logic [3:0] p0, p1;
    logic       ovf0, ovf1;

    logic [7:0] obs [2];

    int checks;
    int failures;

    // reference model state, index 0 = fixed priority, 1 = round robin
    logic [3:0] m_p    [2];
    logic [1:0] m_a    [2];
    logic       m_v    [2];
    logic [1:0] m_last [2];
    logic       m_ovf  [2];

    encoder4x2_serializer #(.RR(0)) dut_fix (
        .clk (clk), .rst (rst), .E (E), .D (D),
        .A (a0), .V (v0), .R (R), .P (p0), .OVF (ovf0)
    );

    encoder4x2_serializer #(.RR(1)) dut_rr (
        .clk (clk), .rst (rst), .E (E), .D (D),
        .A (a1), .V (v1), .R (R), .P (p1), .OVF (ovf1)
    );

    assign obs[0] = {a0, v0, p0, ovf0};
    assign obs[1] = {a1, v1, p1, ovf1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mexp(input int m);
        return {m_a[m], m_v[m], m_p[m], m_ovf[m]};
    endfunction

    // Advance the reference model by one clock using the current inputs.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_p[m]    = 4'b0000;
                m_a[m]    = 2'b00;
                m_v[m]    = 1'b0;
                m_last[m] = 2'b11;
                m_ovf[m]  = 1'b0;
            end else begin
                logic [3:0] cap;
                logic [3:0] clr;
                bit         load;
                int         g;
                int         i;
                cap  = E ? D : 4'b0000;
                load = 0;
                g    = 0;
                if (!m_v[m] || R) begin
                    for (int k = 0; k < 4; k++) begin
                        if (m == 0) i = 3 - k;
                        else        i = (int'(m_last[m]) + 1 + k) % 4;
                        if (!load && m_p[m][i]) begin
                            load = 1;
                            g    = i;
                        end
                    end
                end
                clr       = load ? (4'b0001 << g) : 4'b0000;
                m_ovf[m]  = |(cap & m_p[m] & ~clr);
                m_p[m]    = (m_p[m] & ~clr) | cap;
                if (load) begin
                    m_a[m]    = 2'(g);
                    m_v[m]    = 1'b1;
                    m_last[m] = 2'(g);
                end else if (m_v[m] && R) begin
                    m_v[m] = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; E = 1'b0; D = 4'b0000; R = 1'b1;
        tick(); tick();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs[m] !== 8'b00_0_0000_0) begin
                failures++;
                $display("FAIL reset_state inst%0d got=%b exp=%b", m, obs[m], 8'b00_0_0000_0);
            end
        end
        // capture then reset mid-stream
        rst = 1'b0; E = 1'b1; D = 4'b1010;
        tick();
        checks++;
        if (p0 !== 4'b1010) begin
            failures++;
            $display("FAIL reset_mid_capture got=%b exp=%b", p0, 4'b1010);
        end
        rst = 1'b1; D = 4'b0000;
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs[m] !== 8'b00_0_0000_0) begin
                failures++;
                $display("FAIL reset_mid inst%0d got=%b exp=%b", m, obs[m], 8'b00_0_0000_0);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (v0 !== 1'b0 || v1 !== 1'b0) begin
                failures++;
                $display("FAIL reset_no_emit got=%b%b exp=00", v0, v1);
            end
        end
    endtask

    task automatic test_single();
        E = 1'b1; D = 4'b0100; R = 1'b1;
        tick();
        D = 4'b0000;
        checks++;
        if (p0 !== 4'b0100 || v0 !== 1'b0) begin
            failures++;
            $display("FAIL single_capture got P=%b V=%b exp P=0100 V=0", p0, v0);
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs[m] !== 8'b10_1_0000_0) begin
                failures++;
                $display("FAIL single_emit inst%0d got=%b exp=%b", m, obs[m], 8'b10_1_0000_0);
            end
        end
        tick();
        checks++;
        if (v0 !== 1'b0 || a0 !== 2'b10 || p0 !== 4'b0000) begin
            failures++;
            $display("FAIL single_drain got A=%b V=%b P=%b exp A=10 V=0 P=0000", a0, v0, p0);
        end
    endtask

    task automatic test_burst();
        logic [1:0] exp_a;
        E = 1'b1; D = 4'b1111; R = 1'b1;
        tick();
        D = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            tick();
            exp_a = 2'(3 - c);
            checks++;
            if (a0 !== exp_a || v0 !== 1'b1 || ovf0 !== 1'b0) begin
                failures++;
                $display("FAIL burst_code c=%0d got A=%0d V=%b OVF=%b exp A=%0d V=1 OVF=0",
                         c, a0, v0, ovf0, exp_a);
            end
            checks++;
            if (obs[1] !== mexp(1)) begin
                failures++;
                $display("FAIL burst_rr_model c=%0d got=%b exp=%b", c, obs[1], mexp(1));
            end
        end
        tick();
        checks++;
        if (v0 !== 1'b0) begin
            failures++;
            $display("FAIL burst_end got V=%b exp V=0", v0);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_a;
        rst = 1'b1; tick(); rst = 1'b0;
        E = 1'b1; D = 4'b1001; R = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            tick();
            exp_a = (c % 2 == 0) ? 2'd0 : 2'd3;
            checks++;
            if (a1 !== exp_a || v1 !== 1'b1 || ovf1 !== 1'b1) begin
                failures++;
                $display("FAIL rr_alternate c=%0d got A=%0d V=%b OVF=%b exp A=%0d V=1 OVF=1",
                         c, a1, v1, ovf1, exp_a);
            end
            checks++;
            if (obs[0] !== mexp(0)) begin
                failures++;
                $display("FAIL rr_fix_model c=%0d got=%b exp=%b", c, obs[0], mexp(0));
            end
        end
        D = 4'b0000;
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_backpressure();
        rst = 1'b1; tick(); rst = 1'b0;
        E = 1'b1; D = 4'b0011; R = 1'b0;
        tick();
        D = 4'b0000;
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (a0 !== 2'b01 || v0 !== 1'b1 || p0 !== 4'b0001) begin
                failures++;
                $display("FAIL bp_stall c=%0d got A=%b V=%b P=%b exp A=01 V=1 P=0001",
                         c, a0, v0, p0);
            end
            if (c < 4) tick();
        end
        R = 1'b1;
        tick();
        checks++;
        if (a0 !== 2'b00 || v0 !== 1'b1 || p0 !== 4'b0000) begin
            failures++;
            $display("FAIL bp_release got A=%b V=%b P=%b exp A=00 V=1 P=0000", a0, v0, p0);
        end
        tick();
        checks++;
        if (v0 !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty got V=%b exp V=0", v0);
        end
    endtask

    task automatic test_enable_ovf();
        rst = 1'b1; tick(); rst = 1'b0;
        E = 1'b0; D = 4'b1111; R = 1'b0;
        tick(); tick();
        checks++;
        if (p0 !== 4'b0000 || v0 !== 1'b0) begin
            failures++;
            $display("FAIL en_gating got P=%b V=%b exp P=0000 V=0", p0, v0);
        end
        // fill the slot so later requests stay pending
        E = 1'b1; D = 4'b0100;
        tick();
        D = 4'b0000;
        tick();
        D = 4'b0010;
        tick();
        checks++;
        if (ovf0 !== 1'b0 || p0 !== 4'b0010 || v0 !== 1'b1) begin
            failures++;
            $display("FAIL ovf_first got OVF=%b P=%b V=%b exp OVF=0 P=0010 V=1", ovf0, p0, v0);
        end
        tick();
        checks++;
        if (ovf0 !== 1'b1 || p0 !== 4'b0010) begin
            failures++;
            $display("FAIL ovf_second got OVF=%b P=%b exp OVF=1 P=0010", ovf0, p0);
        end
        D = 4'b0000;
        tick();
        checks++;
        if (ovf0 !== 1'b0) begin
            failures++;
            $display("FAIL ovf_pulse got OVF=%b exp OVF=0", ovf0);
        end
    endtask

    task automatic test_random();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            E   = ($urandom_range(0, 3) != 0);
            D   = 4'($urandom_range(0, 15));
            R   = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 0) D = 4'b0000;
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== mexp(m)) begin
                    failures++;
                    $display("FAIL random_model c=%0d inst%0d got=%b exp=%b", c, m, obs[m], mexp(m));
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1; E = 1'b0; D = 4'b0000; R = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_burst();
        test_round_robin();
        test_backpressure();
        test_enable_ovf();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/encoder4x2_serializer.md
# encoder4x2_serializer

Sequential 4-to-2 encoder, the return path for the team's 2x4 decoder. It captures request pulses on four one-hot lines into a pending register. It then emits one 2-bit code per accepted transfer over a valid/ready handshake, so simultaneous requests are serialized rather than lost. Its output code feeds a downstream `Decoder2x4` `A` input or a status/interrupt consumer.

## Interface
Parameters:
- `RR`, default 0: arbitration mode. 0 = fixed priority (line 3 highest). 1 = round-robin, starting after the last granted line.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset.
- `E`, input, 1: capture enable. When 0, `D` is ignored.
- `D`, input, 4: request lines, sampled every cycle. Any number of bits may be high.
- `A`, output, 2: encoded index of the granted line. Registered.
- `V`, output, 1: `A` is valid. Registered.
- `R`, input, 1: downstream ready. A transfer occurs on a cycle where `V && R`.
- `P`, output, 4: pending-request register, visible for debug and test.
- `OVF`, output, 1: one-cycle pulse. A request arrived on a line that was already pending and not served that cycle.

## Operation
- **Pending update**, every clock: `P <= (P & ~clr) | (E ? D : 4'b0)`.
  - `clr` is the one-hot of the line loaded into the output slot this cycle, or 0 if nothing is loaded.
  - A new request on the line being cleared in the same cycle wins, so the bit stays set.
- **Output slot** has two states:
  - EMPTY (`V=0`).
  - FULL (`V=1`), holding `A`.
- **Load condition**: the slot loads when `(V==0 || R==1) && P!=0`.
  - On load: `A <=` selected index, `V <= 1`, and the selected bit is cleared from `P`.
- **Unload without refill**: if `V && R` and `P==0`, then `V <= 0` and `A` holds its last value.
- **Stall**: while `V && !R`, `A` and `V` hold stable and no line is cleared from `P`.
- **Selection reads registered `P` only.** A request on `D` is never granted in the cycle it arrives.
- **Fixed mode**: the highest set bit of `P` wins.
- **Round-robin mode**:
  - Keep a 2-bit pointer `last`.
  - Search `last+1`, `last+2`, `last+3`, `last` (mod 4) and take the first set bit.
  - `last <=` the granted index on each load.
- **OVF**: `OVF <= |(E ? D : 0) & P & ~clr`. It is a pulse, not sticky. The duplicate request is merged.

## Timing
- **Reset** (`rst=1` at an edge): `P=0`, `A=2'b00`, `V=0`, `OVF=0`, `last=2'b11`, so round-robin first searches line 0.
  - Reset overrides any capture or transfer in that cycle.
  - An in-flight `V` is dropped.
- **Latency**: `D` high at edge k sets `P` at k. `V=1` with the code follows at edge k+1, giving 2 edges from input sample to output.
- **Throughput**: one code per cycle while `R=1` and `P` is nonzero. Back-to-back loads carry no bubble.
- **All-four burst**: `D=4'b1111` captured at k with `R=1` constantly.
  - Fixed mode: codes 3, 2, 1, 0 appear on edges k+1 through k+4.
  - `V` falls at k+5.
- **Empty**: `P==0` and slot EMPTY is idle. Outputs hold their values.
- **Simultaneous**: a transfer, a refill and new captures can all occur in one cycle. The `P` update equation covers this case.
- **`E` low**: pending requests still drain. No new captures.

## Structure
- **Package `encoder_pkg`**:
  - Constants `N_LINES=4` and `IDX_W=2`.
  - Function `onehot2` (2-bit to 4-bit one-hot).
- **Sub-module `pri_sel4`**: combinational.
  - Inputs: `P[3:0]`, `start[1:0]`, `rr`.
  - Outputs: `idx[1:0]`, `any`.
  - `start` is ignored when `rr=0`.
- The top level holds the `P`, `A`, `V`, `last` and `OVF` registers. No other state.

## Test plan
- **Reset mid-stream**: `D=4'b1010` captured, then `rst` asserted one cycle later → next edge `P=0`, `V=0`, `A=00`. No codes emitted afterwards.
- **Single request**: `E=1`, `D=4'b0100` for one cycle, `R=1` → `V=1`, `A=2'b10` two edges after the sample. `V=0` the following edge. `P` returns to 0.
- **Fixed-priority burst**: `RR=0`, `D=4'b1111` for one cycle, `R=1` → `A` sequence 3, 2, 1, 0 on consecutive cycles. `OVF` never pulses.
- **Round-robin**: `RR=1`, after reset hold `D=4'b1001` constantly, `R=1` → `A` alternates 0, 3, 0, 3. `OVF` pulses on each cycle a non-granted line is re-requested while still pending.
- **Backpressure**: `D=4'b0011` captured, `R=0` for 5 cycles → `A=01` and `V=1` stable. `P=4'b0001`. Then `R=1` → `A=00` next cycle, then `V=0`.
- **Enable gating and overflow**: `E=0` with `D=4'b1111` → `P` stays 0. Then `E=1`, `D=4'b0010` for two cycles with `R=0` and the slot full → `OVF=1` on the second cycle only.
